// File: rtl/display_scan_4.sv
// rtl/display_scan_4.sv - four-digit time-multiplexed 7-segment scanner with frame-committed loads
//
// Purpose: presents one hex nibble of the shown value per scan slot, with a
// one-hot digit enable. A load is parked in a pending register and becomes
// the shown value only at a frame wrap, so one frame never mixes two values.
// An optional mode blanks leading zero digits.
//
// Ports:
//   clk       - single clock, rising edge
//   rst_n     - asynchronous active-low reset
//   value     - 16-bit value to display, digit i = value[4*i+3:4*i], digit 0 rightmost
//   load      - one-cycle strobe capturing value into the pending register
//   blank_lz  - 1 = blank leading zero digits (combinational, every cycle)
//   nibble    - hex digit of the active slot, to the 7-segment decoder
//   dig_en    - one-hot active-high digit enable, all zero when the slot is blanked
//   blank     - 1 when the active slot is blanked
//   frame     - one-cycle pulse on each frame wrap
//   pending   - 1 while a loaded value awaits commit

module display_scan_4 #(
   parameter int DIV = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [15:0] value,
   input  logic        load,
   input  logic        blank_lz,
   output logic [3:0]  nibble,
   output logic [3:0]  dig_en,
   output logic        blank,
   output logic        frame,
   output logic        pending
);

   localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [1:0]       idx_q, idx_d;
   logic [15:0]      disp_q, disp_d;
   logic [15:0]      pend_q, pend_d;
   logic             pend_v_q, pend_v_d;
   logic             frame_q, frame_d;

   logic tick;
   logic wrap;

   assign tick = (cnt_q == CNT_W'(DIV - 1));
   assign wrap = tick && (idx_q == 2'd3);

   always_comb begin
      cnt_d    = tick ? '0 : cnt_q + CNT_W'(1);
      idx_d    = tick ? idx_q + 2'd1 : idx_q;
      frame_d  = wrap;
      disp_d   = disp_q;
      pend_d   = pend_q;
      pend_v_d = pend_v_q;

      if (wrap && pend_v_q) begin
         disp_d   = pend_q;
         pend_v_d = 1'b0;
      end

      // Evaluated after the commit so a load landing on the wrap edge stays
      // pending for the next frame instead of being lost.
      if (load) begin
         pend_d   = value;
         pend_v_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q    <= '0;
         idx_q    <= 2'd0;
         disp_q   <= 16'h0000;
         pend_q   <= 16'h0000;
         pend_v_q <= 1'b0;
         frame_q  <= 1'b0;
      end else begin
         cnt_q    <= cnt_d;
         idx_q    <= idx_d;
         disp_q   <= disp_d;
         pend_q   <= pend_d;
         pend_v_q <= pend_v_d;
         frame_q  <= frame_d;
      end
   end

   // Zero flags for the upper digit runs: digit i is a leading zero only
   // when it and every digit above it are zero.
   logic zero_3;
   logic zero_32;
   logic zero_321;

   assign zero_3   = (disp_q[15:12] == 4'h0);
   assign zero_32  = zero_3  && (disp_q[11:8] == 4'h0);
   assign zero_321 = zero_32 && (disp_q[7:4]  == 4'h0);

   always_comb begin
      blank = 1'b0;
      if (blank_lz) begin
         case (idx_q)
            2'd1:    blank = zero_321;
            2'd2:    blank = zero_32;
            2'd3:    blank = zero_3;
            default: blank = 1'b0;
         endcase
      end
   end

   assign nibble  = disp_q[{idx_q, 2'b00} +: 4];
   assign dig_en  = blank ? 4'b0000 : (4'b0001 << idx_q);
   assign frame   = frame_q;
   assign pending = pend_v_q;

endmodule

// File: tb/tb_display_scan_4.sv
// tb/tb_display_scan_4.sv - directed self-checking bench for display_scan_4 (DIV=4 and DIV=1)

module tb_display_scan_4;

   logic        clk;
   logic        rst4_n, rst1_n;
   logic [15:0] value4, value1;
   logic        load4, load1;
   logic        blank_lz4, blank_lz1;
   logic [3:0]  nibble4, nibble1;
   logic [3:0]  dig_en4, dig_en1;
   logic        blank4, blank1;
   logic        frame4, frame1;
   logic        pending4, pending1;

   int n_checks = 0;
   int n_pass   = 0;
   int cyc4     = 0;
   int cyc1     = 0;

   display_scan_4 #(.DIV(4)) u_dut4 (
      .clk      (clk),
      .rst_n    (rst4_n),
      .value    (value4),
      .load     (load4),
      .blank_lz (blank_lz4),
      .nibble   (nibble4),
      .dig_en   (dig_en4),
      .blank    (blank4),
      .frame    (frame4),
      .pending  (pending4)
   );

   display_scan_4 #(.DIV(1)) u_dut1 (
      .clk      (clk),
      .rst_n    (rst1_n),
      .value    (value1),
      .load     (load1),
      .blank_lz (blank_lz1),
      .nibble   (nibble1),
      .dig_en   (dig_en1),
      .blank    (blank1),
      .frame    (frame1),
      .pending  (pending1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, obs, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      if (rst4_n) cyc4++;
      if (rst1_n) cyc1++;
   endtask

   task automatic steps(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   // One full DIV=4 frame with blanking off; call at the frame's first cycle.
   task automatic check_frame(input logic [15:0] shown);
      for (int i = 0; i < 16; i++) begin
         int idx;
         logic [15:0] sh;
         sh  = shown;
         idx = (cyc4 / 4) % 4;
         check($sformatf("nibble4@%0d", cyc4), {12'h0, nibble4}, {12'h0, sh[4*idx +: 4]});
         check($sformatf("dig_en4@%0d", cyc4), {12'h0, dig_en4}, 16'h1 << idx);
         check($sformatf("blank4@%0d", cyc4), {15'h0, blank4}, 16'h0);
         check($sformatf("frame4@%0d", cyc4), {15'h0, frame4},
               {15'h0, (cyc4 != 0 && cyc4 % 16 == 0)});
         step();
      end
   endtask

   // One DIV=4 frame with blanking on, against hand-written enable/blank tables.
   task automatic check_blank_frame(input logic [15:0] shown, input logic [15:0] en_tab,
                                    input logic [3:0] blank_tab);
      for (int i = 0; i < 16; i++) begin
         int idx;
         logic [15:0] sh;
         logic [15:0] et;
         sh  = shown;
         et  = en_tab;
         idx = (cyc4 / 4) % 4;
         check($sformatf("lz_nibble4@%0d", cyc4), {12'h0, nibble4}, {12'h0, sh[4*idx +: 4]});
         check($sformatf("lz_dig_en4@%0d", cyc4), {12'h0, dig_en4}, {12'h0, et[4*idx +: 4]});
         check($sformatf("lz_blank4@%0d", cyc4), {15'h0, blank4}, {15'h0, blank_tab[idx]});
         step();
      end
   endtask

   task automatic load_dut4(input logic [15:0] v);
      value4 = v;
      load4  = 1'b1;
      step();
      load4  = 1'b0;
   endtask

   initial begin
      rst4_n = 1'b0; rst1_n = 1'b0;
      value4 = 16'h0; value1 = 16'h0;
      load4 = 1'b0; load1 = 1'b0;
      blank_lz4 = 1'b0; blank_lz1 = 1'b0;
      steps(2);
      rst4_n = 1'b1;
      cyc4 = 0;

      check("rst_nibble4",  {12'h0, nibble4}, 16'h0);
      check("rst_dig_en4",  {12'h0, dig_en4}, 16'h1);
      check("rst_blank4",   {15'h0, blank4}, 16'h0);
      check("rst_frame4",   {15'h0, frame4}, 16'h0);
      check("rst_pending4", {15'h0, pending4}, 16'h0);

      check_frame(16'h0000);
      check_frame(16'h0000);

      // Load mid-frame: old value stays up until the wrap.
      steps(5);
      load_dut4(16'h12AF);
      check("pend_after_load", {15'h0, pending4}, 16'h1);
      steps(9);
      check("pend_before_wrap", {15'h0, pending4}, 16'h1);
      check("old_nibble_before_wrap", {12'h0, nibble4}, 16'h0);
      check("no_frame_before_wrap", {15'h0, frame4}, 16'h0);
      step();
      check("commit_frame", {15'h0, frame4}, 16'h1);
      check("commit_pending", {15'h0, pending4}, 16'h0);
      check("commit_nibble", {12'h0, nibble4}, 16'hF);
      check_frame(16'h12AF);

      // Last of two loads wins.
      steps(2);
      value4 = 16'h1111; load4 = 1'b1;
      step();
      value4 = 16'h2222;
      step();
      load4 = 1'b0;
      steps(12);
      check_frame(16'h2222);

      // Load on the wrap edge while another value is pending.
      steps(3);
      load_dut4(16'h4444);
      steps(11);
      load_dut4(16'h3333);
      check("wrap_load_pending", {15'h0, pending4}, 16'h1);
      check_frame(16'h4444);
      check("wrap_load_committed", {15'h0, pending4}, 16'h0);
      check_frame(16'h3333);

      // Load on the wrap edge with nothing pending: commits one frame later.
      steps(15);
      load_dut4(16'h5678);
      check("idle_wrap_load_pending", {15'h0, pending4}, 16'h1);
      check_frame(16'h3333);
      check("idle_wrap_load_committed", {15'h0, pending4}, 16'h0);
      check_frame(16'h5678);

      // Leading-zero blanking.
      load_dut4(16'h0050);
      steps(15);
      blank_lz4 = 1'b1;
      check_blank_frame(16'h0050, 16'h0021, 4'b1100);
      load_dut4(16'h0800);
      steps(15);
      check_blank_frame(16'h0800, 16'h0421, 4'b1000);
      load_dut4(16'h0000);
      steps(15);
      check_blank_frame(16'h0000, 16'h0001, 4'b1110);
      blank_lz4 = 1'b0;
      check_frame(16'h0000);

      // Async reset mid-frame discards the pending load.
      steps(5);
      load_dut4(16'h1234);
      check("pend_before_rst4", {15'h0, pending4}, 16'h1);
      #2;
      rst4_n = 1'b0;
      #1;
      check("async_rst_pending4", {15'h0, pending4}, 16'h0);
      check("async_rst_dig_en4", {12'h0, dig_en4}, 16'h1);
      step();
      rst4_n = 1'b1;
      cyc4 = 0;
      check_frame(16'h0000);
      check_frame(16'h0000);

      // DIV=1 instance.
      rst1_n = 1'b1;
      cyc1 = 0;
      check("rst_dig_en1",  {12'h0, dig_en1}, 16'h1);
      check("rst_pending1", {15'h0, pending1}, 16'h0);
      check("rst_frame1",   {15'h0, frame1}, 16'h0);
      for (int i = 0; i < 12; i++) begin
         step();
         check($sformatf("div1_dig_en@%0d", cyc1), {12'h0, dig_en1}, 16'h1 << (cyc1 % 4));
         check($sformatf("div1_frame@%0d", cyc1), {15'h0, frame1}, {15'h0, (cyc1 % 4 == 0)});
      end
      value1 = 16'h00A7; load1 = 1'b1;
      step();
      load1 = 1'b0;
      check("div1_pending", {15'h0, pending1}, 16'h1);
      steps(3);
      check("div1_commit_frame", {15'h0, frame1}, 16'h1);
      check("div1_commit_nibble", {12'h0, nibble1}, 16'h7);
      check("div1_commit_pending", {15'h0, pending1}, 16'h0);
      value1 = 16'hBEEF; load1 = 1'b1;
      step();
      load1 = 1'b0;
      check("div1_pend2", {15'h0, pending1}, 16'h1);
      check("div1_nibble_idx1", {12'h0, nibble1}, 16'hA);
      #2;
      rst1_n = 1'b0;
      #1;
      check("div1_rst_dig_en", {12'h0, dig_en1}, 16'h1);
      check("div1_rst_pending", {15'h0, pending1}, 16'h0);
      check("div1_rst_nibble", {12'h0, nibble1}, 16'h0);
      check("div1_rst_frame", {15'h0, frame1}, 16'h0);
      step();
      rst1_n = 1'b1;
      cyc1 = 0;
      for (int i = 0; i < 8; i++) begin
         step();
         check($sformatf("div1_post_dig_en@%0d", cyc1), {12'h0, dig_en1}, 16'h1 << (cyc1 % 4));
         check($sformatf("div1_post_frame@%0d", cyc1), {15'h0, frame1}, {15'h0, (cyc1 % 4 == 0)});
         check($sformatf("div1_post_nibble@%0d", cyc1), {12'h0, nibble1}, 16'h0);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
